// File: rtl/fifo_word_serializer.sv
// Pulls 32-bit words from the FIFO and sends them LSB-first as bytes.
// Define FIFO_SER_PARITY_EN to add the odd-parity byte_parity output.
module fifo_word_serializer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [31:0]          fifo_data,
  output logic                 fifo_read,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent
`ifdef FIFO_SER_PARITY_EN
  ,
  output logic                 byte_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] shift;

  // Data byte is a pure mux of held registers, so it is stable under stall.
  assign byte_data = shift[{idx, 3'b000} +: 8];

`ifdef FIFO_SER_PARITY_EN
  assign byte_parity = ~^byte_data;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      shift      <= 32'd0;
      words_sent <= '0;
      fifo_read  <= 1'b0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= REQ;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          state     <= LOAD;
          fifo_read <= 1'b0;
        end
        LOAD: begin
          shift      <= fifo_data;
          idx        <= 2'd0;
          state      <= SEND;
          byte_valid <= 1'b1;
          byte_last  <= 1'b0;
        end
        SEND: begin
          if (byte_ready) begin
            if (idx == 2'd3) begin
              words_sent <= words_sent + CNT_WIDTH'(1);
              state      <= IDLE;
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
              busy       <= 1'b0;
            end else begin
              idx       <= idx + 2'd1;
              byte_last <= (idx == 2'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
